// File: rtl/simple_div_256by128_pkg.sv
// Shared definitions for the 2W-by-W restoring divider: default width,
// FSM state encoding and iteration counter sizing.
package simple_div_256by128_pkg;

  localparam int DEFAULT_W = 128;
  localparam int CNT_W     = $clog2(DEFAULT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width for a given operand width W (holds W-1 down to 0).
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/simple_div_256by128_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module simple_div_step
  import simple_div_256by128_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0] rem,
  input  logic         q_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] t;
  logic [W:0] diff;

  // t is W+1 bits wide so the shifted-out remainder MSB is not lost.
  always_comb begin
    t        = {rem, q_msb};
    diff     = t - {1'b0, divisor};
    q_bit    = (t >= {1'b0, divisor});
    rem_next = q_bit ? diff[W-1:0] : t[W-1:0];
  end

endmodule

// File: rtl/simple_div_256by128.sv
// Unsigned 2W-by-W restoring divider with valid/ready handshakes, W cycles per
// division. Define SIMPLE_DIV_OVF_CHECK_EN to flag quotient overflow up front.
module simple_div_256by128
  import simple_div_256by128_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = cnt_width(W);

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   rem_q, quo_q, div_q;
  logic           dbz_q, ovf_q;
  logic [W-1:0]   rem_next;
  logic           q_bit;
  logic           ovf_hit;

`ifdef SIMPLE_DIV_OVF_CHECK_EN
  assign ovf_hit = (dividend[2*W-1:W] >= divisor);
`else
  assign ovf_hit = 1'b0;
`endif

  simple_div_step #(.W(W)) u_step (
    .rem      (rem_q),
    .q_msb    (quo_q[W-1]),
    .divisor  (div_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ((divisor == '0) || ovf_hit) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Quotient and remainder outputs are the working registers themselves; they
  // only settle at the final RUN step and are frozen throughout DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            div_q <= divisor;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
            if (divisor == '0) begin
              quo_q <= '1;
              rem_q <= dividend[W-1:0];
              dbz_q <= 1'b1;
            end else if (ovf_hit) begin
              quo_q <= '1;
              rem_q <= '0;
              ovf_q <= 1'b1;
            end else begin
              rem_q <= dividend[2*W-1:W];
              quo_q <= dividend[W-1:0];
              cnt   <= CW'(W-1);
            end
          end
        end
        RUN: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[W-2:0], q_bit};
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_simple_div_256by128.sv
// Self-checking bench for simple_div_256by128: directed corner cases plus
// randomized operands against an arithmetic reference model.
module tb_simple_div_256by128;

  localparam int W = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  simple_div_256by128 #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic checkOutput(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the full-width operands.
  function automatic void refDiv(input logic [2*W-1:0] n, input logic [W-1:0] d,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic dz, output logic ov, output int lat);
    logic [2*W-1:0] qq, rr, dd;
    dz  = 1'b0;
    ov  = 1'b0;
    lat = W + 1;
    dd  = {{W{1'b0}}, d};
    if (d == '0) begin
      q = '1; r = n[W-1:0]; dz = 1'b1; lat = 1;
`ifdef SIMPLE_DIV_OVF_CHECK_EN
    end else if (n[2*W-1:W] >= d) begin
      q = '1; r = '0; ov = 1'b1; lat = 1;
`endif
    end else begin
      qq = n / dd;
      rr = n % dd;
      q  = qq[W-1:0];
      r  = rr[W-1:0];
    end
  endfunction

  // Present one operand pair and return edges from accept (inclusive) to out_valid.
  task automatic applyStimulus(input logic [2*W-1:0] n, input logic [W-1:0] d, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    dividend = n;
    divisor  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [2*W-1:0] n, input logic [W-1:0] d, input bit check_lat);
    logic [W-1:0] eq, er;
    logic         edz, eov;
    int           elat, lat;
    refDiv(n, d, eq, er, edz, eov, elat);
    applyStimulus(n, d, lat);
    if (check_lat) checkOutput({tag, ".latency"}, 2*W'(lat), 2*W'(elat));
    checkOutput({tag, ".out_valid"}, 2*W'(out_valid), 2*W'(1));
    checkOutput({tag, ".quotient"}, 2*W'(quotient), 2*W'(eq));
    checkOutput({tag, ".remainder"}, 2*W'(remainder), 2*W'(er));
    if (check_lat) begin
      checkOutput({tag, ".div_by_zero"}, 2*W'(div_by_zero), 2*W'(edz));
      checkOutput({tag, ".overflow"}, 2*W'(overflow), 2*W'(eov));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0]   hq, hr, d, hi, lo;
    logic [2*W-1:0] n;
    int             lat, stale, mism;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.in_ready", 2*W'(in_ready), 2*W'(1));
    checkOutput("reset.out_valid", 2*W'(out_valid), 2*W'(0));
    checkOutput("reset.quotient", 2*W'(quotient), 2*W'(0));
    checkOutput("reset.remainder", 2*W'(remainder), 2*W'(0));
    checkOutput("reset.flags", 2*W'({div_by_zero, overflow}), 2*W'(0));
    @(negedge clk);
    rst = 1'b0;

    runOp("d1000_7", 256'd1000, 128'd7, 1'b1);
    runOp("allones", {128'h0, {W{1'b1}}}, {W{1'b1}}, 1'b1);
    runOp("divzero", 256'd5, 128'd0, 1'b1);
`ifdef SIMPLE_DIV_OVF_CHECK_EN
    runOp("overflow", {1'b0, {(2*W-1){1'b1}}}, 128'd3, 1'b1);
`endif

    // Backpressure: hold the result while offering new operands.
    applyStimulus(256'd1000, 128'd7, lat);
    hq = quotient;
    hr = remainder;
    checkOutput("bp.quotient", 2*W'(hq), 2*W'(142));
    mism = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 256'd77;
      divisor  = 128'd0;
      if (quotient !== hq || remainder !== hr || out_valid !== 1'b1 || in_ready !== 1'b0) mism++;
    end
    in_valid = 1'b0;
    checkOutput("bp.stable", 2*W'(mism), 2*W'(0));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput("bp.release.in_ready", 2*W'(in_ready), 2*W'(1));
    checkOutput("bp.release.out_valid", 2*W'(out_valid), 2*W'(0));

    // Reset in the middle of RUN, then a clean operation.
    @(negedge clk);
    dividend = 256'd1000;
    divisor  = 128'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (60) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst.out_valid", 2*W'(out_valid), 2*W'(0));
    checkOutput("midrst.in_ready", 2*W'(in_ready), 2*W'(1));
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("midrst.stale", 2*W'(stale), 2*W'(0));
    runOp("after_rst", 256'd1000, 128'd7, 1'b1);

    // Randomized operands with high half below divisor, issued back to back.
    for (int i = 0; i < 200; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      if (i % 4 == 0) d = d >> $urandom_range(0, 120);
      if (d == '0) d = 128'd1;
      hi = {$urandom, $urandom, $urandom, $urandom};
      hi = hi % d;
      lo = {$urandom, $urandom, $urandom, $urandom};
      n  = {hi, lo};
      runOp($sformatf("rand%0d", i), n, d, (i % 25 == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
